// File: rtl/ad7606_frame_reader.sv
// AD7606-family controller: standby/reset sequencing, conversion start, BUSY handshake and
// serial readout over one or two DOUT lanes, assembled into one parallel frame.
module ad7606_frame_reader #(
    parameter int unsigned CHANNELS     = 8,
    parameter int unsigned BITS         = 16,
    parameter int unsigned DOUT_LINES   = 2,
    parameter int unsigned SCLK_HALF    = 2,
    parameter int unsigned RESET_CYCLES = 4,
    parameter int unsigned CONV_LOW     = 2,
    parameter int unsigned AUTO_PERIOD  = 0,
    parameter int unsigned BUSY_TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     power,
    input  logic                     start,
    input  logic                     busy,
    input  logic                     douta,
    input  logic                     doutb,
    output logic                     conv,
    output logic                     n_cs,
    output logic                     sclk,
    output logic                     reset,
    output logic                     stby,
    output logic [CHANNELS*BITS-1:0] frame,
    output logic                     frame_valid,
    output logic                     err
);

    localparam int unsigned FW        = CHANNELS * BITS;
    localparam int unsigned LW        = FW / DOUT_LINES;
    localparam int unsigned EDGES     = 2 * LW;
    localparam int unsigned HALF_LAST = SCLK_HALF - 1;
    localparam int unsigned AUTO_LAST = AUTO_PERIOD - 1;

    typedef enum logic [2:0] {
        StOff, StReset, StIdle, StConv, StWaitHi, StWaitLo, StRead, StDone
    } state_e;

    state_e          state_q, state_d;
    logic [31:0]     cnt_q, cnt_d;
    logic [31:0]     half_q, half_d;
    logic [31:0]     tog_q, tog_d;
    logic [31:0]     auto_q, auto_d;
    logic            sclk_q, sclk_d;
    logic            err_q, err_d;
    logic [FW-1:0]   sh_q, sh_d;
    logic [FW-1:0]   frame_q, frame_d;
    logic [FW-1:0]   sh_shifted;
    logic            auto_fire;

    // Shift register holds channel 0 in its top word once a readout completes; with two
    // lanes the upper half is fed by douta and the lower half by doutb.
    if (DOUT_LINES == 2) begin : g_two_lanes
        assign sh_shifted = {sh_q[FW-2:LW], douta, sh_q[LW-2:0], doutb};
    end else begin : g_one_lane
        logic unused_doutb;
        assign sh_shifted   = {sh_q[FW-2:0], douta};
        assign unused_doutb = doutb;
    end

    assign auto_fire = (AUTO_PERIOD != 0) && (auto_q == AUTO_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        half_d  = half_q;
        tog_d   = tog_q;
        sclk_d  = sclk_q;
        sh_d    = sh_q;
        frame_d = frame_q;
        err_d   = 1'b0;

        if (state_q == StOff || state_q == StReset) begin
            auto_d = '0;
        end else if (auto_q != AUTO_LAST) begin
            auto_d = auto_q + 32'd1;
        end else begin
            auto_d = auto_q;
        end

        unique case (state_q)
            StOff: begin
                if (power) begin
                    state_d = StReset;
                    cnt_d   = '0;
                end
            end
            StReset: begin
                if (cnt_q == RESET_CYCLES - 1) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StIdle: begin
                if (start || auto_fire) begin
                    state_d = StConv;
                    cnt_d   = '0;
                    auto_d  = '0;
                end
            end
            StConv: begin
                if (cnt_q == CONV_LOW - 1) begin
                    state_d = StWaitHi;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StWaitHi: begin
                if (busy) begin
                    state_d = StWaitLo;
                    cnt_d   = '0;
                end else if (cnt_q == BUSY_TIMEOUT) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StWaitLo: begin
                if (!busy) begin
                    state_d = StRead;
                    half_d  = '0;
                    tog_d   = '0;
                    sclk_d  = 1'b1;
                end else if (cnt_q == BUSY_TIMEOUT) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StRead: begin
                // tog_q runs past EDGES twice: once for the n_cs hold, once for the gap to DONE.
                if (tog_q == EDGES + 1) begin
                    state_d = StDone;
                    for (int unsigned k = 0; k < CHANNELS; k++) begin
                        frame_d[k*BITS +: BITS] = sh_q[(CHANNELS-1-k)*BITS +: BITS];
                    end
                end else if (half_q == HALF_LAST) begin
                    half_d = '0;
                    tog_d  = tog_q + 32'd1;
                    if (tog_q < EDGES) begin
                        sclk_d = ~sclk_q;
                        if (!sclk_q) begin
                            sh_d = sh_shifted;
                        end
                    end
                end else begin
                    half_d = half_q + 32'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
        endcase

        if (!power) begin
            state_d = StOff;
            cnt_d   = '0;
            half_d  = '0;
            tog_d   = '0;
            auto_d  = '0;
            sclk_d  = 1'b1;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q <= StOff;
            cnt_q   <= '0;
            half_q  <= '0;
            tog_q   <= '0;
            auto_q  <= '0;
            sclk_q  <= 1'b1;
            err_q   <= 1'b0;
            sh_q    <= '0;
            frame_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            half_q  <= half_d;
            tog_q   <= tog_d;
            auto_q  <= auto_d;
            sclk_q  <= sclk_d;
            err_q   <= err_d;
            sh_q    <= sh_d;
            frame_q <= frame_d;
        end
    end

    assign conv        = (state_q != StConv);
    assign n_cs        = !((state_q == StRead) && (tog_q <= EDGES));
    assign sclk        = sclk_q;
    assign reset       = (state_q == StReset);
    assign stby        = (state_q != StOff);
    assign frame       = frame_q;
    assign frame_valid = (state_q == StDone);
    assign err         = err_q;

endmodule

// File: doc/ad7606_frame_reader.md
# ad7606_frame_reader

Parametrised AD7606-family controller that sequences standby, reset, conversion start, BUSY wait and serial readout over one or two DOUT lines, and assembles all channels into one parallel frame. It sits between the ADC pins and the sample-processing logic. It succeeds the fixed-function ad7606 controller with configurable channel count, word width, SCLK rate, DOUT lane count, free-running or triggered sampling, and a BUSY timeout.

## Interface
- CHANNELS, 8, channels read per frame (1..8; must be even when DOUT_LINES=2)
- BITS, 16, bits per channel word
- DOUT_LINES, 2, serial data lanes used (1 = DOUTA only, 2 = DOUTA+DOUTB)
- SCLK_HALF, 2, clk cycles per SCLK half-period (>=1)
- RESET_CYCLES, 4, clk cycles the ADC reset pin is held high after power-up
- CONV_LOW, 2, clk cycles conv is held low before its starting rising edge
- AUTO_PERIOD, 0, clk cycles between conversion starts when free-running; 0 = trigger only
- BUSY_TIMEOUT, 255, clk cycles allowed for busy to rise, then to fall
- clk  in  1  system clock
- n_rst  in  1  synchronous active-low reset
- power  in  1  1 = ADC enabled, 0 = standby
- start  in  1  one-cycle conversion request (ignored unless IDLE)
- busy  in  1  ADC BUSY pin
- douta  in  1  ADC DOUTA pin
- doutb  in  1  ADC DOUTB pin (unused when DOUT_LINES=1)
- conv  out  1  ADC CONVST (A and B tied)
- n_cs  out  1  ADC chip select, active low
- sclk  out  1  ADC serial clock, idles high
- reset  out  1  ADC RESET pin, active high
- stby  out  1  ADC STBY pin, 0 = standby
- frame  out  CHANNELS*BITS  last complete frame, channel 0 in bits [BITS-1:0]
- frame_valid  out  1  one-cycle pulse when frame updates
- err  out  1  one-cycle pulse on BUSY timeout

## Operation
- States: OFF, RESET, IDLE, CONV, WAIT_HI, WAIT_LO, READ, DONE.
- OFF: stby=0, all pins idle. power=1 -> RESET.
- RESET: stby=1, reset=1 for RESET_CYCLES cycles -> IDLE.
- IDLE: start=1, or free-run counter reaching AUTO_PERIOD (AUTO_PERIOD>0) -> CONV. Free-run counter restarts when CONV is entered.
- CONV: conv=0 for CONV_LOW cycles, then conv=1 -> WAIT_HI.
- WAIT_HI: busy=1 -> WAIT_LO. Timeout -> err pulse, IDLE.
- WAIT_LO: busy=0 -> READ (n_cs=0). Timeout -> err pulse, IDLE.
- READ: N = CHANNELS*BITS/DOUT_LINES SCLK periods, MSB first. Lane A carries channels 0..CHANNELS/DOUT_LINES-1 in order; lane B carries the rest.
- DONE: n_cs=1, frame loaded from shift registers, frame_valid=1 for one cycle -> IDLE.
- power=0 in any state -> OFF on the next edge, with all pins at reset values. frame is retained and no frame_valid is issued. An in-flight readout is discarded.
- start outside IDLE is dropped and not queued.

## Timing
- Reset (n_rst=0 at a clk edge): state OFF, conv=1, n_cs=1, sclk=1, reset=0, stby=0, frame=0, frame_valid=0, err=0, all counters 0.
- SCLK: each period is a falling edge followed by a rising edge, with each level held SCLK_HALF cycles. The first falling edge occurs SCLK_HALF cycles after n_cs falls.
- Sampling: douta/doutb are sampled on the clk edge that drives sclk 0->1.
- n_cs rises SCLK_HALF cycles after the last rising sclk edge. DONE follows in the next cycle.
- Readout length from n_cs falling to frame_valid: (2N+1)*SCLK_HALF+1 cycles.
- Timeout counter resets on entry to WAIT_HI and WAIT_LO. A timeout fires when the count equals BUSY_TIMEOUT with the awaited level not yet seen.
- Simultaneous start and power=0: power wins (OFF).

## Test plan
- Power-up: n_rst low 2 cycles, power=1 -> stby=1 next cycle, reset high exactly 4 cycles, then IDLE with conv=1, n_cs=1, sclk=1.
- Triggered frame, defaults: start pulse, busy model rises 1 cycle after conv rises and stays high 4 cycles. ADC model shifts channel k = 0x1111*k on its lane. Required: 64 SCLK periods, then frame_valid once, with frame[15:0]=0x0000 and frame[127:112]=0x7777.
- Single lane (DOUT_LINES=1, CHANNELS=4, BITS=12): word k = 0xA50+k on douta. Required: 48 SCLK periods and frame = {0xA53,0xA52,0xA51,0xA50}.
- BUSY timeout: busy held low after conv -> err pulses exactly 256 cycles after WAIT_HI entry, state returns to IDLE, n_cs stays 1, frame unchanged.
- Power drop mid-read: power=0 at SCLK period 20 -> next cycle stby=0, n_cs=1, sclk=1, with no frame_valid. power=1 again -> full RESET sequence runs before the next conversion.
- Free-run (AUTO_PERIOD=500): the first 3 conv rising edges are 500 cycles apart and each produces one frame_valid. A start pulse during READ adds no extra conversion.
